// File: rtl/ext_bus_target.sv
// Responder for the multiplexed 16-bit external bus. It synchronises the pad strobes,
// demultiplexes the ALE address phases and turns each OE_N/WE_N cycle into one req/ready transaction.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for an oe_n fall (read) or a we_n rise (write)
// RD_REQ   | read request issued, waiting for mem_ready
// RD_DRIVE | read data on the bus, waiting for oe_n to rise
// RD_ABORT | oe_n rose early; keep mem_req until mem_ready, never drive
// WR_REQ   | write request issued, waiting for mem_ready
module ext_bus_target #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       dio_in,
    output logic [15:0]       dio_out,
    output logic              dio_oe,
    input  logic              ale0,
    input  logic              ale1,
    input  logic              oe_n,
    input  logic              we_n,
    input  logic              bhe_n,
    output logic              mem_req,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [1:0]        mem_wmask,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              err,
    input  logic              err_clr
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_REQ   = 3'd1,
        RD_DRIVE = 3'd2,
        RD_ABORT = 3'd3,
        WR_REQ   = 3'd4
    } state_t;

    // Bit positions inside the synchroniser bundle
    localparam int B_ALE0 = 16;
    localparam int B_ALE1 = 17;
    localparam int B_OE   = 18;
    localparam int B_WE   = 19;
    localparam int B_BHE  = 20;
    localparam int B_VLD  = 21;
    localparam int BW     = 22;

    // A constant 1 travels with the pad samples; edges are only trusted once
    // both the last stage and its delayed copy hold real samples taken after reset.
    logic [SYNC_STAGES-1:0][BW-1:0] sync_q;
    logic [BW-1:0]                  cur;
    logic [15:0]                    prev_dio;
    logic                           prev_ale0, prev_ale1, prev_oe_n, prev_we_n, prev_vld;

    logic        edge_ok, oe_fall, oe_rise, we_rise, ale0_fall, ale1_fall;
    logic [15:0] addr_lo, addr_hi;
    logic [31:0] addr_full;

    state_t             state, state_nxt;
    logic               req_nxt, rw_nxt, doe_nxt, err_nxt, err_set;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [15:0]        wdata_nxt, dout_nxt;
    logic [1:0]         wmask_nxt;

    assign cur = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '0;
            prev_dio  <= '0;
            prev_ale0 <= 1'b0;
            prev_ale1 <= 1'b0;
            prev_oe_n <= 1'b0;
            prev_we_n <= 1'b0;
            prev_vld  <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], {1'b1, bhe_n, we_n, oe_n, ale1, ale0, dio_in}};
            prev_dio  <= cur[15:0];
            prev_ale0 <= cur[B_ALE0];
            prev_ale1 <= cur[B_ALE1];
            prev_oe_n <= cur[B_OE];
            prev_we_n <= cur[B_WE];
            prev_vld  <= cur[B_VLD];
        end
    end

    assign edge_ok   = cur[B_VLD] & prev_vld;
    assign oe_fall   = edge_ok &  prev_oe_n & ~cur[B_OE];
    assign oe_rise   = edge_ok & ~prev_oe_n &  cur[B_OE];
    assign we_rise   = edge_ok & ~prev_we_n &  cur[B_WE];
    assign ale0_fall = edge_ok &  prev_ale0 & ~cur[B_ALE0];
    assign ale1_fall = edge_ok &  prev_ale1 & ~cur[B_ALE1];

    // ADDR_W is expected to be 32 or less; upper address bits are simply dropped
    assign addr_full = {addr_hi, addr_lo};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_lo <= '0;
            addr_hi <= '0;
        end else begin
            if (ale0_fall) addr_lo <= prev_dio;
            if (ale1_fall) addr_hi <= prev_dio;
        end
    end

    always_comb begin
        state_nxt = state;
        req_nxt   = mem_req;
        rw_nxt    = mem_rw;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        wmask_nxt = mem_wmask;
        dout_nxt  = dio_out;
        doe_nxt   = dio_oe;
        err_set   = 1'b0;

        case (state)
            IDLE: begin
                if (we_rise || oe_fall) begin
                    req_nxt   = 1'b1;
                    addr_nxt  = addr_full[ADDR_W-1:0];
                    wmask_nxt = {~cur[B_BHE], ~addr_lo[0]};
                end
                if (we_rise) begin
                    state_nxt = WR_REQ;
                    rw_nxt    = 1'b1;
                    wdata_nxt = cur[15:0];
                    err_set   = oe_fall;
                end else if (oe_fall) begin
                    state_nxt = RD_REQ;
                    rw_nxt    = 1'b0;
                end
            end
            RD_REQ: begin
                if (mem_ready) begin
                    req_nxt = 1'b0;
                    // A strobe that ended in the same cycle leaves nothing to drive
                    if (oe_rise) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = RD_DRIVE;
                        dout_nxt  = mem_rdata;
                        doe_nxt   = 1'b1;
                    end
                end else if (oe_rise) begin
                    state_nxt = RD_ABORT;
                end
            end
            RD_DRIVE: begin
                if (!cur[B_WE]) begin
                    state_nxt = IDLE;
                    doe_nxt   = 1'b0;
                    err_set   = 1'b1;
                end else if (oe_rise) begin
                    state_nxt = IDLE;
                    doe_nxt   = 1'b0;
                end
            end
            RD_ABORT, WR_REQ: begin
                if (mem_ready) begin
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                req_nxt   = 1'b0;
                doe_nxt   = 1'b0;
            end
        endcase

        if (state != IDLE && (oe_fall || we_rise)) err_set = 1'b1;

        if (err_set)      err_nxt = 1'b1;
        else if (err_clr) err_nxt = 1'b0;
        else              err_nxt = err;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_rw    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            dio_out   <= '0;
            dio_oe    <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            mem_req   <= req_nxt;
            mem_rw    <= rw_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            mem_wmask <= wmask_nxt;
            dio_out   <= dout_nxt;
            dio_oe    <= doe_nxt;
            err       <= err_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ext_bus_target.sv
// Directed bench for ext_bus_target: drives the pad strobes like the external
// initiator and plays the memory side by hand, checking with immediate assertions.
module tb_ext_bus_target;

    localparam int SYNC_STAGES = 2;
    localparam int ADDR_W      = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [15:0]       dio_in;
    logic [15:0]       dio_out;
    logic              dio_oe;
    logic              ale0, ale1, oe_n, we_n, bhe_n;
    logic              mem_req, mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [1:0]        mem_wmask;
    logic [15:0]       mem_rdata;
    logic              mem_ready;
    logic              busy, err, err_clr;

    int errors = 0;
    int checks = 0;
    int req_rises = 0;
    int oe_cycles = 0;
    logic req_d = 1'b0;
    int r0;
    int oe0;
    int n;

    ext_bus_target #(.SYNC_STAGES(SYNC_STAGES), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .dio_in    (dio_in),
        .dio_out   (dio_out),
        .dio_oe    (dio_oe),
        .ale0      (ale0),
        .ale1      (ale1),
        .oe_n      (oe_n),
        .we_n      (we_n),
        .bhe_n     (bhe_n),
        .mem_req   (mem_req),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .err       (err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        req_d <= mem_req;
        if (mem_req === 1'b1 && req_d !== 1'b1) req_rises <= req_rises + 1;
        if (dio_oe === 1'b1) oe_cycles <= oe_cycles + 1;
    end

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int k;
        k = 0;
        while (mem_req !== 1'b1 && k < 30) begin
            tick(1);
            k++;
        end
        check(tag, 32'(mem_req), 1);
    endtask

    task automatic pulse_ready(input logic [15:0] rd);
        mem_rdata = rd;
        mem_ready = 1'b1;
        tick(1);
        mem_ready = 1'b0;
    endtask

    task automatic ale_phase(input logic sel_hi, input logic [15:0] val);
        dio_in = val;
        if (sel_hi) ale1 = 1'b1; else ale0 = 1'b1;
        tick(3);
        ale0 = 1'b0;
        ale1 = 1'b0;
        tick(SYNC_STAGES + 3);
    endtask

    task automatic pad_write(input logic [15:0] val);
        dio_in = val;
        we_n = 1'b0;
        tick(3);
        we_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        dio_in = '0;
        ale0 = 1'b0; ale1 = 1'b0;
        oe_n = 1'b1; we_n = 1'b1; bhe_n = 1'b1;
        mem_rdata = '0; mem_ready = 1'b0; err_clr = 1'b0;

        // Reset values and quiet release with idle pads
        tick(3);
        check("rst_dio_oe", 32'(dio_oe), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_dio_out", 32'(dio_out), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        reset_n = 1'b1;
        tick(8);
        check("release_no_req", 32'(mem_req), 0);
        check("release_busy", 32'(busy), 0);

        // Write to 0x00AB1234, both bytes
        ale_phase(1'b0, 16'h1234);
        ale_phase(1'b1, 16'h00AB);
        bhe_n = 1'b0;
        pad_write(16'hBEEF);
        wait_req("wr_req");
        check("wr_rw", 32'(mem_rw), 1);
        check("wr_addr", mem_addr, 32'h00AB1234);
        check("wr_wdata", 32'(mem_wdata), 32'hBEEF);
        check("wr_wmask", 32'(mem_wmask), 3);
        check("wr_busy", 32'(busy), 1);
        tick(2);
        check("wr_req_hold", 32'(mem_req), 1);
        check("wr_addr_hold", mem_addr, 32'h00AB1234);
        pulse_ready(16'h0000);
        check("wr_req_drop", 32'(mem_req), 0);
        check("wr_idle", 32'(busy), 0);

        // Read with 4-cycle wait; bhe_n high and odd address enable no byte lane
        bhe_n = 1'b1;
        ale_phase(1'b0, 16'h0005);
        ale_phase(1'b1, 16'h0000);
        oe_n = 1'b0;
        wait_req("rd_req");
        check("rd_rw", 32'(mem_rw), 0);
        check("rd_addr", mem_addr, 32'h00000005);
        check("rd_wmask", 32'(mem_wmask), 0);
        tick(3);
        check("rd_oe_before_ready", 32'(dio_oe), 0);
        pulse_ready(16'h5A5A);
        check("rd_req_drop", 32'(mem_req), 0);
        check("rd_dio_oe", 32'(dio_oe), 1);
        check("rd_dio_out", 32'(dio_out), 32'h5A5A);
        tick(4);
        check("rd_dio_oe_hold", 32'(dio_oe), 1);
        oe_n = 1'b1;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (dio_oe !== 1'b0 && n < SYNC_STAGES + 1);
        check("rd_oe_release", 32'(dio_oe), 0);
        check("rd_idle", 32'(busy), 0);

        // Read abort: request stays up until mem_ready, bus never driven
        oe0 = oe_cycles;
        oe_n = 1'b0;
        wait_req("ab_req");
        oe_n = 1'b1;
        tick(6);
        check("ab_req_held", 32'(mem_req), 1);
        check("ab_busy", 32'(busy), 1);
        pulse_ready(16'hFFFF);
        check("ab_req_drop", 32'(mem_req), 0);
        tick(2);
        check("ab_idle", 32'(busy), 0);
        check("ab_err", 32'(err), 0);
        check("ab_never_drove", 32'(oe_cycles - oe0), 0);

        // WE_N pulse during RD_REQ: flagged and ignored, read still completes
        r0 = req_rises;
        oe_n = 1'b0;
        wait_req("pe_req");
        pad_write(16'h7777);
        tick(5);
        check("pe_err", 32'(err), 1);
        check("pe_still_read", 32'(mem_rw), 0);
        check("pe_req_held", 32'(mem_req), 1);
        pulse_ready(16'h1357);
        check("pe_dio_oe", 32'(dio_oe), 1);
        check("pe_dio_out", 32'(dio_out), 32'h1357);
        oe_n = 1'b1;
        tick(5);
        check("pe_release", 32'(dio_oe), 0);
        check("pe_one_req", req_rises - r0, 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("pe_err_clr", 32'(err), 0);

        // WE_N low while driving read data releases the bus at once
        oe_n = 1'b0;
        wait_req("wd_req");
        pulse_ready(16'h0F0F);
        check("wd_drive", 32'(dio_oe), 1);
        we_n = 1'b0;
        tick(4);
        check("wd_release", 32'(dio_oe), 0);
        check("wd_err", 32'(err), 1);
        check("wd_idle", 32'(busy), 0);
        oe_n = 1'b1;
        tick(4);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("wd_err_clr", 32'(err), 0);

        // OE_N fall and WE_N rise together: write wins, err set
        dio_in = 16'hC0DE;
        oe_n = 1'b0;
        we_n = 1'b1;
        wait_req("both_req");
        check("both_rw", 32'(mem_rw), 1);
        check("both_wdata", 32'(mem_wdata), 32'hC0DE);
        check("both_err", 32'(err), 1);
        pulse_ready(16'h0000);
        tick(4);
        check("both_no_read", 32'(mem_req), 0);
        oe_n = 1'b1;
        tick(5);
        check("both_idle", 32'(busy), 0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;

        // Back-to-back writes, only ALE0 changes between them
        r0 = req_rises;
        ale_phase(1'b1, 16'h00CD);
        ale_phase(1'b0, 16'h0010);
        pad_write(16'h1111);
        wait_req("b2b_req0");
        check("b2b_addr0", mem_addr, 32'h00CD0010);
        check("b2b_wdata0", 32'(mem_wdata), 32'h1111);
        check("b2b_wmask0", 32'(mem_wmask), 1);
        pulse_ready(16'h0000);
        ale_phase(1'b0, 16'h0012);
        pad_write(16'h2222);
        wait_req("b2b_req1");
        check("b2b_addr1", mem_addr, 32'h00CD0012);
        check("b2b_wdata1", 32'(mem_wdata), 32'h2222);
        check("b2b_wmask1", 32'(mem_wmask), 1);
        pulse_ready(16'h0000);
        tick(2);
        check("b2b_count", req_rises - r0, 2);

        // Asynchronous reset while driving read data
        oe_n = 1'b0;
        wait_req("ar_req");
        pulse_ready(16'hA5A5);
        check("ar_drive", 32'(dio_oe), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_dio_oe", 32'(dio_oe), 0);
        check("ar_mem_req", 32'(mem_req), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_err", 32'(err), 0);
        check("ar_dio_out", 32'(dio_out), 0);
        tick(2);
        reset_n = 1'b1;

        // OE_N held low across reset release: nothing until a real edge
        tick(8);
        check("ar_no_edge", 32'(mem_req), 0);
        oe_n = 1'b1;
        tick(4);
        oe_n = 1'b0;
        wait_req("ar_real_edge");
        check("ar_real_rw", 32'(mem_rw), 0);
        pulse_ready(16'h3C3C);
        check("ar_real_data", 32'(dio_out), 32'h3C3C);
        oe_n = 1'b1;
        tick(5);
        check("ar_final_idle", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
